serial_add_seq: RTL and testbench

Sequencer for the bit-serial adder datapath. It captures operand A in parallel and operand B either in parallel or serially from `in_b`, LSB first. It then drives a one-bit full-adder slice for WIDTH cycles and commits the sum and carry-out with a one-cycle `done` pulse. It sits between the control/stimulus logic and the serial adder, and owns all load, shift and carry sequencing for that adder.

---
 rtl/serial_add_seq.sv | 131 +++++++++++++
 tb/tb_serial_add_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Sequencer for a bit-serial adder: loads A/B (B parallel or LSB-first serial),
// runs WIDTH full-adder cycles and commits {cout,sum} with a one-cycle done pulse.
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             src_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_b,
  input  logic             cin,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOADB, S_ADD, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_nxt;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (ci & (x ^ y));
  endfunction

  assign s_bit = fa_sum(ra[0], rb[0], c);
  assign c_nxt = fa_carry(ra[0], rb[0], c);

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = src_sel ? S_LOADB : S_ADD;
      S_LOADB: begin
        if (abort)             state_nxt = S_IDLE;
        else if (cnt == LAST)  state_nxt = S_ADD;
      end
      S_ADD: begin
        if (abort)             state_nxt = S_IDLE;
        else if (cnt == LAST)  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status is decoded from the next state so busy/done come straight off flops
  always_comb begin
    busy_nxt = (state_nxt == S_LOADB) || (state_nxt == S_ADD);
    done_nxt = (state_nxt == S_DONE);
  end

  // Operand shift registers, carry, accumulator and committed result
  always_ff @(posedge clk) begin
    if (reset) begin
      ra   <= '0;
      rb   <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ra  <= a;
            c   <= cin;
            cnt <= '0;
            if (!src_sel) rb <= b;
          end
        end
        S_LOADB: begin
          if (!abort) begin
            rb  <= {in_b, rb[WIDTH-1:1]};
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
          end
        end
        S_ADD: begin
          if (!abort) begin
            c   <= c_nxt;
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            acc <= {s_bit, acc[WIDTH-1:1]};
            if (cnt == LAST) begin
              cnt  <= '0;
              sum  <= {s_bit, acc[WIDTH-1:1]};
              cout <= c_nxt;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized self-checking bench for serial_add_seq against an arithmetic reference.
module tb_serial_add_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, src_sel, in_b, cin, abort;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
    .a(a), .b(b), .in_b(in_b), .cin(cin), .abort(abort),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic eb, input logic ed);
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, eb});
    check({tag, "_done"}, {31'b0, done}, {31'b0, ed});
    check({tag, "_sum"},  {28'b0, sum},  {28'b0, exp_sum});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_cout});
  endtask

  // One operation from IDLE; abort_at=k raises abort for the k-th busy edge (0 = none).
  // noisy drives spurious start/abort where they must be ignored.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                        input logic oser, input int abort_at, input bit noisy);
    int         total;
    logic [W:0] r;
    total   = oser ? 2 * W : W;
    src_sel = oser;
    a       = oa;
    b       = oser ? W'($urandom) : ob;
    cin     = ocin;
    start   = 1'b1;
    abort   = 1'b0;
    step();
    start   = 1'b0;
    src_sel = 1'($urandom);
    cin     = 1'($urandom);
    a       = W'($urandom);
    b       = W'($urandom);
    check_outs("accept", 1'b1, 1'b0);
    for (int k = 1; k <= total; k++) begin
      in_b  = (oser && k <= W) ? ob[k-1] : 1'($urandom);
      abort = (k == abort_at);
      start = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      step();
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        check_outs("abort", 1'b0, 1'b0);
        step();
        check_outs("abort_idle", 1'b0, 1'b0);
        return;
      end
      if (k < total) begin
        check_outs("run", 1'b1, 1'b0);
      end else begin
        r        = oa + ob + ocin;
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        check_outs("commit", 1'b0, 1'b1);
      end
    end
    // DONE cycle: start and abort here must be ignored
    start = noisy;
    abort = noisy ? 1'($urandom) : 1'b0;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_outs("post_done", 1'b0, 1'b0);
    if (noisy) begin
      step();
      check_outs("no_queue", 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_sel = 1'b0; in_b = 1'b0;
    cin = 1'b0; abort = 1'b0; a = '0; b = '0;
    exp_sum = '0; exp_cout = 1'b0;
    step(); step();
    check_outs("reset", 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_outs("idle", 1'b0, 1'b0);

    run_op(4'b0101, 4'b0111, 1'b0, 1'b0, 0, 1'b0);
    check("par_5p7", {27'b0, cout, sum}, 32'h0C);
    run_op(4'b1111, 4'b0001, 1'b0, 1'b0, 0, 1'b0);
    check("wrap", {27'b0, cout, sum}, 32'h10);
    run_op(4'b1111, 4'b1111, 1'b1, 1'b0, 0, 1'b0);
    check("max", {27'b0, cout, sum}, 32'h1F);
    run_op(4'b0101, 4'b0101, 1'b0, 1'b1, 0, 1'b0);
    check("serial", {27'b0, cout, sum}, 32'h0A);
    run_op(4'b1001, 4'b0110, 1'b1, 1'b0, 0, 1'b1);
    check("ignored_start", {27'b0, cout, sum}, 32'h10);

    run_op(4'd5, 4'd7, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'd3, 4'd3, 1'b0, 1'b0, 2, 1'b0);
    check("abort_keep", {27'b0, cout, sum}, 32'h0C);
    run_op(4'd9, 4'd9, 1'b1, 1'b1, 3, 1'b0);
    check("abort_loadb", {27'b0, cout, sum}, 32'h0C);

    // Reset while in LOADB clears everything including the last result
    src_sel = 1'b1; a = 4'd6; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0; in_b = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b0);
    run_op(4'd2, 4'd3, 1'b0, 1'b0, 0, 1'b0);
    check("after_reset", {27'b0, cout, sum}, 32'h05);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra_t, rb_t;
      logic         rc_t, rs_t;
      int           ab;
      ra_t = W'($urandom);
      rb_t = W'($urandom);
      rc_t = 1'($urandom);
      rs_t = 1'($urandom);
      ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rs_t ? 2 * W : W) : 0;
      run_op(ra_t, rb_t, rc_t, rs_t, ab, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
